uxn_device_ram_arbiter: RTL
===========================

Name: uxn_device_ram_arbiter

Overview:
- Shares port A (read/write) of the 256x8 Varvara device-page RAM between two requesters: the CPU (DEI/DEO) and the host peripheral bridge (controller/mouse/datetime updates).
- Arbitration is round-robin with a registered command stage to the RAM.
- Emits a DEO event strobe on every accepted CPU write so device handlers can react.
- Port B of the RAM (screen/audio read-only consumers) is untouched by this block.

Parameters:
- ADDR_W, 8, device RAM address width (256 ports)
- DATA_W, 8, data width
- HOST_WR_MASK, 16'hFFFF, one bit per 16-byte device page; host writes are allowed where the bit is 1 (used only with the optional feature)

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  port address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle accept pulse
- cpu_rvalid  out  1  read data valid pulse
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  same as CPU
- host_gnt, host_rvalid  out  1  same as CPU
- rdata  out  DATA_W  shared read data, equal to ram_q
- ram_addr  out  ADDR_W  to RAM addr_a
- ram_wdata  out  DATA_W  to RAM data_a
- ram_we  out  1  to RAM we_a
- ram_q  in  DATA_W  from RAM q_a
- deo_valid  out  1  CPU write accepted
- deo_addr  out  ADDR_W  address of that write
- deo_data  out  DATA_W  data of that write
- host_wr_err  out  1  sticky; host write was dropped (optional feature only, else tied 0)

Behaviour:
- Reset (async assert, sync release): every gnt, rvalid, ram_we and deo_valid = 0; ram_addr, ram_wdata, deo_addr, deo_data = 0; last_owner = HOST, so the CPU wins the first tie; host_wr_err = 0.
- Eligibility: a requester is eligible when its req = 1 and its gnt was not asserted in the previous cycle. This prevents a stale req being re-granted; each requester gets at most one grant per 2 cycles.
- Choice: one eligible requester wins. Both eligible: the one that is not last_owner wins, then last_owner updates.
- Cycle N (decision): the winner's command is registered. At N+1: ram_addr/ram_wdata/ram_we are driven, winner gnt = 1 for exactly one cycle, and for a CPU write deo_valid = 1 with deo_addr/deo_data.
- No winner: ram_we = 0; ram_addr/ram_wdata hold their previous values.
- Read latency: RAM samples at the N+1 edge, so ram_q is valid at N+2. The owner's rvalid = 1 at N+2 (registered pipe of gnt & ~we). rdata = ram_q combinationally.
- Write: RAM q_a returns write-through data, but no rvalid is raised.
- Throughput: alternating CPU/host traffic sustains one access per cycle. A single requester sustains one access per 2 cycles.
- Same-address CPU write and host read in consecutive grants: the read returns the written value (RAM ordering preserved, no bypass needed).
- Reset mid-operation: pending gnt/rvalid/deo pulses are cancelled immediately; requesters re-arbitrate after release.

Optional Feature:
- UXN_DEVRAM_HOST_GUARD_EN defined: a host write to a page whose HOST_WR_MASK bit (addr[7:4]) is 0 is still granted (host_gnt pulses), but ram_we stays 0 and host_wr_err sets. host_wr_err clears only on reset. Host reads are unaffected.
- Undefined: all host writes are performed; host_wr_err is constant 0.

Decomposition:
- Shared package uxn_devram_pkg: owner_t enum {OWN_CPU, OWN_HOST}, DEV_PAGE_W = 4, DEVRAM_ADDR_W = 8, DEVRAM_DATA_W = 8.
- One natural sub-module: uxn_rr_arbiter2 (2-way round-robin with last_owner register and previous-grant masking). The command/return pipeline stays in the top.

Test Plan:
- Reset then cpu_req write addr 0x18 data 0x42 -> cpu_gnt and ram_we at cycle 2, deo_valid with deo_addr=0x18, deo_data=0x42; host signals stay quiet.
- CPU read 0x18 after that write -> cpu_gnt at cycle N+1, cpu_rvalid at N+2 with rdata=0x42.
- cpu_req and host_req (reads, 0x80 and 0x90) held for 6 cycles -> grants alternate CPU, HOST, CPU, HOST...; CPU first after reset; never two gnts in one cycle.
- Single requester host_req held high for 6 cycles -> host_gnt pulses on every other cycle, 3 pulses total.
- With UXN_DEVRAM_HOST_GUARD_EN and HOST_WR_MASK=16'hFFFE, host write 0x05 <- 0x7F -> host_gnt=1, ram_we=0, host_wr_err=1; a following CPU read of 0x05 returns the old value.
- rst_n asserted in the cycle between cpu_gnt (read) and cpu_rvalid -> cpu_rvalid never pulses; after release the CPU is granted first.

Source files
------------

// File: rtl/uxn_devram_pkg.sv
// Shared types and sizes for the Varvara device-page RAM port-A arbiter.
package uxn_devram_pkg;

   typedef enum logic {
      OWN_CPU  = 1'b0,
      OWN_HOST = 1'b1
   } owner_t;

   localparam int unsigned DEV_PAGE_W    = 4;
   localparam int unsigned DEVRAM_ADDR_W = 8;
   localparam int unsigned DEVRAM_DATA_W = 8;

endpackage : uxn_devram_pkg

// File: rtl/uxn_rr_arbiter2.sv
// Two-way round-robin arbiter (CPU vs host). A requester granted in the
// previous decision is masked for one cycle, so a request still held while
// its grant pulse is visible cannot be re-granted.
module uxn_rr_arbiter2
   import uxn_devram_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_cpu_i,
   input  logic req_host_i,
   output logic win_cpu_o,
   output logic win_host_o,
   output logic gnt_cpu_o,
   output logic gnt_host_o
);

   owner_t last_q, last_d;
   logic   gnt_cpu_q, gnt_host_q;
   logic   elig_cpu, elig_host;

   // Eligibility, winner selection and next owner
   always_comb begin
      elig_cpu   = req_cpu_i  & ~gnt_cpu_q;
      elig_host  = req_host_i & ~gnt_host_q;
      win_cpu_o  = elig_cpu & (~elig_host | (last_q == OWN_HOST));
      win_host_o = elig_host & ~win_cpu_o;
      last_d     = last_q;
      if (win_cpu_o) begin
         last_d = OWN_CPU;
      end else if (win_host_o) begin
         last_d = OWN_HOST;
      end
   end

   // Grant pulses one cycle after the decision; owner history for fairness
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q     <= OWN_HOST;
         gnt_cpu_q  <= 1'b0;
         gnt_host_q <= 1'b0;
      end else begin
         last_q     <= last_d;
         gnt_cpu_q  <= win_cpu_o;
         gnt_host_q <= win_host_o;
      end
   end

   assign gnt_cpu_o  = gnt_cpu_q;
   assign gnt_host_o = gnt_host_q;

endmodule : uxn_rr_arbiter2

// File: rtl/uxn_device_ram_arbiter.sv
// Port-A arbiter for the 256x8 device-page RAM shared by the CPU (DEI/DEO)
// and the host peripheral bridge. Registered command stage, DEO strobe on
// accepted CPU writes, rvalid two cycles after the decision.
// Optional: UXN_DEVRAM_HOST_GUARD_EN drops host writes to pages whose
// HOST_WR_MASK bit is 0 and raises sticky host_wr_err.
module uxn_device_ram_arbiter
   import uxn_devram_pkg::*;
#(
   parameter int unsigned ADDR_W       = DEVRAM_ADDR_W,
   parameter int unsigned DATA_W       = DEVRAM_DATA_W,
   parameter logic [15:0] HOST_WR_MASK = 16'hFFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_q,
   output logic              deo_valid,
   output logic [ADDR_W-1:0] deo_addr,
   output logic [DATA_W-1:0] deo_data,
   output logic              host_wr_err
);

   logic                  win_cpu, win_host, win_any;
   logic                  sel_we;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [DEV_PAGE_W-1:0] host_page;
   logic                  page_ok;
   logic                  host_blocked;

   logic [ADDR_W-1:0]     ram_addr_q;
   logic [DATA_W-1:0]     ram_wdata_q;
   logic                  ram_we_q;
   logic                  cmd_we_q;
   logic                  deo_valid_q;
   logic [ADDR_W-1:0]     deo_addr_q;
   logic [DATA_W-1:0]     deo_data_q;
   logic                  cpu_rvalid_q, host_rvalid_q;

   uxn_rr_arbiter2 u_arb (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_cpu_i  (cpu_req),
      .req_host_i (host_req),
      .win_cpu_o  (win_cpu),
      .win_host_o (win_host),
      .gnt_cpu_o  (cpu_gnt),
      .gnt_host_o (host_gnt)
   );

   // Winner's command mux
   always_comb begin
      win_any   = win_cpu | win_host;
      sel_we    = win_cpu ? cpu_we    : host_we;
      sel_addr  = win_cpu ? cpu_addr  : host_addr;
      sel_wdata = win_cpu ? cpu_wdata : host_wdata;
   end

   assign host_page = host_addr[ADDR_W-1 -: DEV_PAGE_W];
   assign page_ok   = HOST_WR_MASK[host_page];

`ifdef UXN_DEVRAM_HOST_GUARD_EN
   logic host_wr_err_q;

   assign host_blocked = win_host & host_we & ~page_ok;

   // Sticky record of any dropped host write; only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_wr_err_q <= 1'b0;
      end else if (host_blocked) begin
         host_wr_err_q <= 1'b1;
      end
   end

   assign host_wr_err = host_wr_err_q;
`else
   // Mask has no effect without the guard
   assign host_blocked = 1'b0 & page_ok;
   assign host_wr_err  = 1'b0;
`endif

   // Registered RAM command, DEO strobe and read-valid pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_we_q      <= 1'b0;
         cmd_we_q      <= 1'b0;
         deo_valid_q   <= 1'b0;
         deo_addr_q    <= '0;
         deo_data_q    <= '0;
         cpu_rvalid_q  <= 1'b0;
         host_rvalid_q <= 1'b0;
      end else begin
         if (win_any) begin
            ram_addr_q  <= sel_addr;
            ram_wdata_q <= sel_wdata;
            cmd_we_q    <= sel_we;
         end
         ram_we_q    <= win_any & sel_we & ~host_blocked;
         deo_valid_q <= win_cpu & cpu_we;
         if (win_cpu && cpu_we) begin
            deo_addr_q <= cpu_addr;
            deo_data_q <= cpu_wdata;
         end
         cpu_rvalid_q  <= cpu_gnt  & ~cmd_we_q;
         host_rvalid_q <= host_gnt & ~cmd_we_q;
      end
   end

   assign ram_addr    = ram_addr_q;
   assign ram_wdata   = ram_wdata_q;
   assign ram_we      = ram_we_q;
   assign deo_valid   = deo_valid_q;
   assign deo_addr    = deo_addr_q;
   assign deo_data    = deo_data_q;
   assign cpu_rvalid  = cpu_rvalid_q;
   assign host_rvalid = host_rvalid_q;
   assign rdata       = ram_q;

endmodule : uxn_device_ram_arbiter
